didactic_uart_rx: RTL and testbench
===================================

# didactic_uart_rx

UART receiver that gives the FPGA verification platform the far end of the SoC's `uart_tx` pin. It is instantiated beside the Didactic top and receives 8-bit frames at a programmable baud rate, with optional parity. Received bytes are buffered in a small FIFO behind a valid/ready stream port. Framing, parity and overrun errors are reported as sticky flags, so the platform can check SoC serial output without a host PC.

## Interface
Parameters:
- `FIFO_DEPTH`, default 8: number of receive buffer entries. Must be a power of 2, at least 2.
- `DIV_W`, default 16: width of the baud divisor.

Ports:
- `clk_in`, input, 1: block clock. The single clock domain.
- `reset`, input, 1: reset, asynchronous and active-low.
- `uart_rx`, input, 1: serial line, asynchronous to `clk_in`, idles high.
- `cfg_div`, input, DIV_W: oversample divisor. One oversample tick every `cfg_div+1` clocks. 16 ticks make one bit.
- `cfg_parity_en`, input, 1: when 1, frames carry a parity bit after the data.
- `cfg_parity_odd`, input, 1: 1 selects odd parity, 0 selects even.
- `rx_data`, output, 8: byte at the FIFO head.
- `rx_valid`, output, 1: FIFO not empty.
- `rx_ready`, input, 1: consumer accepts the head byte.
- `rx_busy`, output, 1: a frame is in progress (state is not IDLE).
- `err_frame`, output, 1: sticky flag, stop bit sampled low.
- `err_parity`, output, 1: sticky flag, parity mismatch.
- `err_overrun`, output, 1: sticky flag, byte arrived while the FIFO was full.
- `err_clr`, input, 1: one-cycle pulse that clears all sticky flags.

## Operation
- **Input synchronizer:** two-flop synchronizer on `uart_rx`. Both flops reset to 1.
- **Tick generator:** the divisor counter is cleared on start-bit detection.
- **Config latch:** `cfg_div`, `cfg_parity_en` and `cfg_parity_odd` are latched on start detection. Changing them mid-frame has no effect on the current frame.
- **Framing:** data is sent LSB first.

State machine:
- IDLE → START when the synchronized line is low.
- START: after 8 ticks (mid-bit), sample the line.
  - Sample low → DATA.
  - Sample high → IDLE. This is a glitch: no error, no push.
- DATA: sample every 16 ticks, 8 samples shifted in LSB first. Then go to PARITY if `cfg_parity_en`, otherwise STOP.
- PARITY: sample after 16 ticks, then check.
  - Even mode: the XOR of data and parity bit must be 0.
  - Odd mode: it must be 1.
  - On mismatch, set the parity-failed marker. Always go to STOP.
- STOP: sample after 16 ticks.
  - Sample high and parity OK → push the byte, go to IDLE.
  - Sample high and parity failed → set `err_parity`, discard the byte, go to IDLE.
  - Sample low → set `err_frame`, discard the byte, go to WAIT_IDLE.
- WAIT_IDLE (break handling): stay until the synchronized line is high, then go to IDLE. No further errors are raised while waiting.

FIFO:
- First-word-fall-through: `rx_data` shows the head whenever `rx_valid` is 1.
- A pop happens on any cycle with `rx_valid && rx_ready`.
- Push while full with no pop in the same cycle: the byte is dropped and `err_overrun` is set. FIFO contents are unchanged.
- Push and pop in the same cycle while full: both succeed, no overrun.
- Push and pop in the same cycle while empty: only the push takes effect. `rx_valid` rises the next cycle.
- Read and write pointers are `log2(FIFO_DEPTH)+1` bits wide. Wrap is natural.

Sticky flags:
- `err_clr` clears all three flags.
- An error event in the same cycle as `err_clr` wins: that flag reads 1 on the next cycle.

Reset:
- Active-low `reset` may arrive at any time, including mid-frame.
- It returns the FSM to IDLE, empties the FIFO and clears the flags.
- Reset values: `rx_data`=0, `rx_valid`=0, `rx_busy`=0, all `err_*`=0.

## Timing
- Let D = `cfg_div+1`. One bit lasts 16·D clocks.
- Synchronizer latency is 2 clocks.
- **Receive latency:** from the first `clk_in` edge that samples `uart_rx` low (start bit) to `rx_valid` rising with an empty FIFO:
  - No parity: 2 + 8·D + 9·16·D + 1 clocks.
  - Parity enabled: add 16·D.
- **Data path:** the push occurs on the clock of the stop-bit sample. `rx_data` and `rx_valid` are registered and update the following cycle.
- **Back-to-back frames:** a new start edge is accepted the cycle after the FSM returns to IDLE. Minimum supported stop length is therefore one bit.
- **`rx_busy`:** rises the cycle after start detection. Falls in the cycle the FSM re-enters IDLE.
- **Error flags:** assert the cycle after the sampling clock that detects the error.

## Test plan
- **Nominal 8N1:** `cfg_div`=0, parity off, send 0xA5.
  - `rx_valid` rises 155 clocks after the start edge, with `rx_data`=0xA5.
  - Hold `rx_ready`=1 → `rx_valid` drops the next cycle. All flags stay 0.
- **Odd parity:** `cfg_div`=3, odd parity.
  - Send 0x3C with parity bit 1 → byte 0x3C accepted.
  - Send 0x3C with parity bit 0 → no push, `err_parity`=1.
  - Pulse `err_clr` → flag returns to 0.
- **Framing error and break:** drive the line low for 30 bit times.
  - `err_frame`=1, no push, `rx_busy` stays high (WAIT_IDLE) until the line returns high.
  - The next frame 0x5A is received correctly.
- **Glitch rejection:** with `cfg_div`=0, a 5-clock low pulse on `uart_rx` → back to IDLE, no push, no error flags.
- **Overrun and simultaneous events:** `rx_ready`=0, send 9 bytes 0x00..0x08 with `FIFO_DEPTH`=8.
  - The 9th byte is dropped and `err_overrun`=1. Popping returns 0x00..0x07 in order.
  - Repeat with `rx_ready` pulsed on the same cycle as the 9th push → no overrun, 0x08 is retained.
  - Assert `err_clr` on the same cycle as the overrun → `err_overrun` reads 1.
- **Reset mid-operation:** assert `reset` low during DATA of a frame with 3 bytes queued.
  - Immediately after reset, all outputs take their reset values.
  - After release, a fresh frame 0xC3 is received as the only FIFO entry.

Source files
------------

// File: rtl/didactic_uart_rx.sv
// UART receiver: 16x oversampled 8-bit frames with optional parity, a first-word-fall-through
// receive FIFO behind a valid/ready port, and sticky framing/parity/overrun flags.
module didactic_uart_rx #(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             uart_rx,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             cfg_parity_en,
    input  logic             cfg_parity_odd,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             rx_busy,
    output logic             err_frame,
    output logic             err_parity,
    output logic             err_overrun,
    input  logic             err_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    logic             sync_q1;
    logic             rx_s;
    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_l;
    logic             par_en_l;
    logic             par_odd_l;
    logic [3:0]       tcnt;
    logic [2:0]       bitn;
    logic [7:0]       shreg;
    logic             par_bad;
    logic             push_r;
    logic             tick;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             full;
    logic             pop;
    logic             push_ok;

    // NOTE: non-blocking assignments keep these two flops a true shift chain; blocking
    // assignments here would collapse the synchronizer into a single stage.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            sync_q1 <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            sync_q1 <= uart_rx;
            rx_s    <= sync_q1;
        end
    end

    assign tick    = (div_cnt == div_l);
    assign rx_busy = (state != S_IDLE);

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            div_cnt    <= '0;
            div_l      <= '0;
            par_en_l   <= 1'b0;
            par_odd_l  <= 1'b0;
            tcnt       <= '0;
            bitn       <= '0;
            shreg      <= '0;
            par_bad    <= 1'b0;
            push_r     <= 1'b0;
            err_frame  <= 1'b0;
            err_parity <= 1'b0;
        end else begin
            push_r <= 1'b0;
            // NOTE: a later non-blocking assignment in the same block wins, so an error
            // raised below overrides this clear when both happen in one cycle.
            if (err_clr) begin
                err_frame  <= 1'b0;
                err_parity <= 1'b0;
            end
            if (state != S_IDLE && state != S_WAIT_IDLE) begin
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
            end
            unique case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state     <= S_START;
                        div_cnt   <= '0;
                        div_l     <= cfg_div;
                        par_en_l  <= cfg_parity_en;
                        par_odd_l <= cfg_parity_odd;
                        tcnt      <= '0;
                        bitn      <= '0;
                        par_bad   <= 1'b0;
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (tcnt == 4'd7) begin
                            tcnt  <= '0;
                            state <= rx_s ? S_IDLE : S_DATA;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        tcnt <= tcnt + 1'b1;
                        if (tcnt == 4'd15) begin
                            shreg <= {rx_s, shreg[7:1]};
                            bitn  <= bitn + 1'b1;
                            if (bitn == 3'd7) begin
                                state <= par_en_l ? S_PARITY : S_STOP;
                            end
                        end
                    end
                end
                S_PARITY: begin
                    if (tick) begin
                        tcnt <= tcnt + 1'b1;
                        if (tcnt == 4'd15) begin
                            par_bad <= ((^shreg) ^ rx_s) != par_odd_l;
                            state   <= S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        tcnt <= tcnt + 1'b1;
                        if (tcnt == 4'd15) begin
                            if (!rx_s) begin
                                err_frame <= 1'b1;
                                state     <= S_WAIT_IDLE;
                            end else if (par_bad) begin
                                err_parity <= 1'b1;
                                state      <= S_IDLE;
                            end else begin
                                push_r <= 1'b1;
                                state  <= S_IDLE;
                            end
                        end
                    end
                end
                S_WAIT_IDLE: begin
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // shreg is stable for many clocks after the stop sample, so the FIFO writes it directly.
    assign rx_valid = (wptr != rptr);
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop      = rx_valid && rx_ready;
    assign push_ok  = push_r && (!full || pop);

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            wptr        <= '0;
            rptr        <= '0;
            err_overrun <= 1'b0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop)     rptr <= rptr + 1'b1;
            if (err_clr) err_overrun <= 1'b0;
            if (push_r && full && !pop) err_overrun <= 1'b1;
        end
    end

    // NOTE: the storage array has no reset; it is never observed while empty because
    // rx_data is forced to zero whenever rx_valid is low.
    always_ff @(posedge clk_in) begin
        if (push_ok) mem[wptr[AW-1:0]] <= shreg;
    end

    assign rx_data = rx_valid ? mem[rptr[AW-1:0]] : 8'h00;

endmodule

// File: tb/tb_didactic_uart_rx.sv
// Self-checking bench for didactic_uart_rx: frame-level reference model with a per-cycle
// output compare, directed scenarios pinned by literal expectations, then randomized traffic.
module tb_didactic_uart_rx;

    localparam int DEPTH = 8;

    logic        clk_in = 1'b0;
    logic        reset = 1'b0;
    logic        uart_rx = 1'b1;
    logic [15:0] cfg_div = '0;
    logic        cfg_parity_en = 1'b0;
    logic        cfg_parity_odd = 1'b0;
    logic        rx_ready = 1'b0;
    logic        err_clr = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_busy;
    logic        err_frame;
    logic        err_parity;
    logic        err_overrun;

    always #5 clk_in = ~clk_in;

    didactic_uart_rx #(.FIFO_DEPTH(DEPTH), .DIV_W(16)) dut (
        .clk_in        (clk_in),
        .reset         (reset),
        .uart_rx       (uart_rx),
        .cfg_div       (cfg_div),
        .cfg_parity_en (cfg_parity_en),
        .cfg_parity_odd(cfg_parity_odd),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_busy       (rx_busy),
        .err_frame     (err_frame),
        .err_parity    (err_parity),
        .err_overrun   (err_overrun),
        .err_clr       (err_clr)
    );

    typedef enum {EV_PUSH, EV_PERR, EV_FERR} ev_kind_t;
    typedef struct {
        int         at;
        ev_kind_t   kind;
        logic [7:0] b;
    } ev_t;

    int         compared = 0;
    int         mismatched = 0;
    int         cyc = 0;
    int         last_start = 0;
    int         rise_cyc = -1;
    logic       prev_valid = 1'b0;
    ev_t        evq[$];
    logic [7:0] mq[$];
    bit         m_ferr, m_perr, m_ovr, m_busy;
    int         busy_from = 1;
    int         busy_to = 0;
    bit         chk_en = 0;
    bit         rnd_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clr_model();
        mq.delete();
        evq.delete();
        m_ferr = 0; m_perr = 0; m_ovr = 0; m_busy = 0;
        busy_from = 1; busy_to = 0;
    endtask

    // Reference model: scheduled frame outcomes applied to a byte queue and flag set.
    task automatic model_step();
        bit         pop, push;
        logic [7:0] pb;
        pop  = (mq.size() > 0) && rx_ready;
        push = 0;
        pb   = 8'h00;
        if (err_clr) begin m_ferr = 0; m_perr = 0; m_ovr = 0; end
        for (int i = evq.size() - 1; i >= 0; i--) begin
            if (evq[i].at == cyc) begin
                case (evq[i].kind)
                    EV_PUSH: begin push = 1; pb = evq[i].b; end
                    EV_PERR: m_perr = 1;
                    default: m_ferr = 1;
                endcase
                evq.delete(i);
            end
        end
        if (pop) mq.delete(0);
        if (push) begin
            if (mq.size() < DEPTH) mq.push_back(pb);
            else m_ovr = 1;
        end
        m_busy = (cyc >= busy_from) && (cyc < busy_to);
    endtask

    always @(posedge clk_in) begin
        cyc++;
        if (reset) model_step();
    end

    always @(negedge clk_in) begin
        if (chk_en) begin
            check("rx_valid", rx_valid, mq.size() > 0);
            if (mq.size() > 0) check("rx_data", rx_data, mq[0]);
            check("rx_busy", rx_busy, m_busy);
            check("err_frame", err_frame, m_ferr);
            check("err_parity", err_parity, m_perr);
            check("err_overrun", err_overrun, m_ovr);
        end
        if (rx_valid === 1'b1 && prev_valid === 1'b0) rise_cyc = cyc;
        prev_valid = rx_valid;
    end

    always @(posedge clk_in) begin
        if (rnd_en) begin
            #1;
            rx_ready = 1'($urandom_range(0, 1));
            err_clr  = ($urandom_range(0, 63) == 0);
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic pulse_clr();
        step(); err_clr = 1'b1;
        step(); err_clr = 1'b0;
    endtask

    task automatic drain(input int first, input int n);
        step(); rx_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_in);
            check("pop_order", rx_data, first + i);
        end
        step(); rx_ready = 1'b0;
    endtask

    // pulse_sel: 1 pulses rx_ready, 2 pulses err_clr, on the clock the byte reaches the FIFO.
    task automatic send_frame(input logic [7:0] data, input int div, input bit pen,
                              input bit podd, input bit flip, input int pulse_sel);
        int         d, nb, s, e, pc;
        bit         pbit;
        logic [10:0] bits;
        d    = div + 1;
        pbit = podd ? ~(^data) : ^data;
        pbit = pbit ^ flip;
        nb   = pen ? 11 : 10;
        bits = pen ? {1'b1, pbit, data, 1'b0} : {1'b0, 1'b1, data, 1'b0};
        step();
        cfg_div        = div[15:0];
        cfg_parity_en  = pen;
        cfg_parity_odd = podd;
        s  = cyc + 1;
        e  = s + 2 + 8 * d + (nb - 1) * 16 * d;
        pc = e + 1;
        last_start = s;
        busy_from  = s + 2;
        busy_to    = e;
        if (!pen || ((($countones(data) + int'(pbit)) % 2) == (podd ? 1 : 0)))
            evq.push_back('{pc, EV_PUSH, data});
        else
            evq.push_back('{e, EV_PERR, 8'h00});
        for (int i = 0; i < nb * 16 * d; i++) begin
            if (i > 0) step();
            uart_rx = bits[i / (16 * d)];
            if (i == 48 * d) begin
                cfg_div        = 16'($urandom_range(0, 7));
                cfg_parity_en  = ~pen;
                cfg_parity_odd = ~podd;
            end
            if (pulse_sel == 1) rx_ready = (cyc + 1 == pc);
            if (pulse_sel == 2) err_clr  = (cyc + 1 == pc);
        end
    endtask

    task automatic send_break(input int nbits, input int div);
        int d, s, len;
        d = div + 1;
        step();
        cfg_div       = div[15:0];
        cfg_parity_en = 1'b0;
        uart_rx       = 1'b0;
        s   = cyc + 1;
        len = nbits * 16 * d;
        busy_from = s + 2;
        busy_to   = s + len + 2;
        evq.push_back('{s + 2 + 8 * d + 9 * 16 * d, EV_FERR, 8'h00});
        repeat (len - 1) step();
        check("break_busy", rx_busy, 1);
        check("break_err_frame", err_frame, 1);
        step();
        uart_rx = 1'b1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  s, dv, gap;
        bit  pen, podd, flip;

        clr_model();
        repeat (3) @(posedge clk_in);
        #1;
        chk_en = 1;
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_rx_busy", rx_busy, 0);
        check("reset_flags", {err_frame, err_parity, err_overrun}, 3'b000);
        reset = 1'b1;
        repeat (4) step();

        // Nominal 8N1 at full rate.
        rise_cyc = -1;
        send_frame(8'hA5, 0, 0, 0, 0, 0);
        check("latency_8n1", rise_cyc - last_start, 155);
        check("nominal_data", rx_data, 8'hA5);
        step(); rx_ready = 1'b1;
        @(negedge clk_in); check("nominal_valid_hold", rx_valid, 1);
        @(negedge clk_in); check("nominal_valid_drop", rx_valid, 0);
        step(); rx_ready = 1'b0;
        check("nominal_flags", {err_frame, err_parity, err_overrun}, 3'b000);

        // Odd parity, divisor 3.
        send_frame(8'h3C, 3, 1, 1, 0, 0);
        step();
        check("odd_ok_valid", rx_valid, 1);
        check("odd_ok_data", rx_data, 8'h3C);
        drain(8'h3C, 1);
        send_frame(8'h3C, 3, 1, 1, 1, 0);
        step();
        check("odd_bad_err", err_parity, 1);
        check("odd_bad_nopush", rx_valid, 0);
        pulse_clr();
        @(negedge clk_in); check("odd_clr", err_parity, 0);

        // Break for 30 bit times, then a clean frame.
        send_break(30, 1);
        repeat (64) step();
        check("break_released", rx_busy, 0);
        send_frame(8'h5A, 1, 0, 0, 0, 0);
        step();
        check("post_break_data", rx_data, 8'h5A);
        check("post_break_sticky", err_frame, 1);
        drain(8'h5A, 1);
        pulse_clr();

        // Five-clock glitch.
        step();
        cfg_div = '0;
        uart_rx = 1'b0;
        s = cyc + 1;
        busy_from = s + 2;
        busy_to   = s + 10;
        repeat (4) step();
        step(); uart_rx = 1'b1;
        check("glitch_busy", rx_busy, 1);
        repeat (20) step();
        check("glitch_idle", rx_busy, 0);
        check("glitch_nopush", rx_valid, 0);
        check("glitch_flags", {err_frame, err_parity, err_overrun}, 3'b000);

        // Overrun: ninth byte dropped.
        for (int i = 0; i < 9; i++) send_frame(8'(i), 0, 0, 0, 0, 0);
        step();
        check("overrun_set", err_overrun, 1);
        drain(0, 8);
        @(negedge clk_in); check("overrun_empty", rx_valid, 0);
        pulse_clr();

        // Pop on the same clock as the ninth push.
        for (int i = 0; i < 8; i++) send_frame(8'(i), 0, 0, 0, 0, 0);
        send_frame(8'h08, 0, 0, 0, 0, 1);
        step();
        check("simul_pop_no_overrun", err_overrun, 0);
        drain(1, 8);

        // err_clr on the same clock as the overrun.
        for (int i = 0; i < 8; i++) send_frame(8'(i), 0, 0, 0, 0, 0);
        send_frame(8'h08, 0, 0, 0, 0, 2);
        step();
        check("clr_vs_overrun", err_overrun, 1);
        drain(0, 8);
        pulse_clr();

        // Reset during DATA with three bytes queued.
        for (int i = 0; i < 3; i++) send_frame(8'($urandom_range(0, 255)), 0, 0, 0, 0, 0);
        step();
        check("pre_reset_valid", rx_valid, 1);
        cfg_div = '0;
        cfg_parity_en = 1'b0;
        uart_rx = 1'b0;
        s = cyc + 1;
        busy_from = s + 2;
        busy_to   = 1 << 30;
        repeat (40) step();
        check("mid_frame_busy", rx_busy, 1);
        reset   = 1'b0;
        uart_rx = 1'b1;
        clr_model();
        #1;
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_busy", rx_busy, 0);
        check("rst_flags", {err_frame, err_parity, err_overrun}, 3'b000);
        repeat (3) step();
        reset = 1'b1;
        repeat (5) step();
        send_frame(8'hC3, 0, 0, 0, 0, 0);
        step();
        check("post_reset_data", rx_data, 8'hC3);
        drain(8'hC3, 1);
        @(negedge clk_in); check("post_reset_single", rx_valid, 0);

        // Randomized traffic with random back-pressure and flag clears.
        rnd_en = 1;
        for (int n = 0; n < 25; n++) begin
            dv   = $urandom_range(0, 3);
            pen  = 1'($urandom_range(0, 1));
            podd = 1'($urandom_range(0, 1));
            flip = pen && ($urandom_range(0, 3) == 0);
            send_frame(8'($urandom_range(0, 255)), dv, pen, podd, flip, 0);
            gap = $urandom_range(0, 20);
            repeat (gap) step();
        end
        rnd_en = 0;
        step();
        err_clr  = 1'b0;
        rx_ready = 1'b1;
        repeat (20) step();
        check("final_drained", rx_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
